// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg: shared state type, default clock rate and debounce length helper
package button_debounce_pkg;
  localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;
  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_state_e;
  function automatic int debounce_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one active-high button bit; two-flop synchroniser, stability counter, press/release pulses
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse
);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  logic             r_sync1, r_sync2, r_press, r_release;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  btn_state_e       r_state, w_state_nxt;
  logic             w_diff, w_done;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_state   <= RELEASED;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_cnt     <= w_cnt_nxt;
      r_state   <= w_state_nxt;
      r_press   <= w_done && (w_state_nxt == PRESSED);
      r_release <= w_done && (w_state_nxt == RELEASED);
    end
  end
  // any sample matching the stable level restarts the filter
  always_comb begin
    w_diff      = r_sync2 != (r_state == PRESSED);
    w_done      = w_diff && (r_cnt == CNT_MAX);
    w_cnt_nxt   = (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
    w_state_nxt = w_done ? ((r_state == PRESSED) ? RELEASED : PRESSED) : r_state;
  end
  always_comb begin
    o_pressed       = r_state == PRESSED;
    o_press_pulse   = r_press;
    o_release_pulse = r_release;
  end
endmodule

// File: rtl/button_debounce.sv
// button_debounce: per-button debounce for the button PIO, with pressed levels and edge pulses
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int NUM_BUTTONS = 4,
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int DEBOUNCE_US = 10000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw_i,
  output logic [NUM_BUTTONS-1:0] btn_clean_o,
  output logic [NUM_BUTTONS-1:0] pressed_o,
  output logic [NUM_BUTTONS-1:0] press_pulse_o,
  output logic [NUM_BUTTONS-1:0] release_pulse_o
);
  localparam int   STABLE_CYCLES = debounce_cycles(CLK_FREQ_HZ, DEBOUNCE_US);
  localparam logic IDLE          = (ACTIVE_LOW != 0);
  logic [NUM_BUTTONS-1:0] w_pin_pressed;
  if (STABLE_CYCLES < 2) begin : g_bad_cfg
    $error("button_debounce: debounce window shorter than 2 cycles");
  end
  // channels work in pressed-high polarity; pin polarity is restored on btn_clean_o
  assign w_pin_pressed = btn_raw_i ^ {NUM_BUTTONS{IDLE}};
  assign btn_clean_o   = pressed_o ^ {NUM_BUTTONS{IDLE}};
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_btn          (w_pin_pressed[i]),
      .o_pressed      (pressed_o[i]),
      .o_press_pulse  (press_pulse_o[i]),
      .o_release_pulse(release_pulse_o[i])
    );
  end
endmodule
